// File: rtl/cu_edge_data_read_extract_if.sv
// Bus bundle between the CU read-return path, the edge-data consumer and the issuer.
// The slave side is the extract block; the master side drives returns, pops and issues.
interface cu_edge_data_read_extract_if #(
  parameter int DATA_SIZE_READ  = 4,
  parameter int CACHELINE_BYTES = 128,
  parameter int DEPTH           = 16
);
  localparam int OFF_W  = $clog2(CACHELINE_BYTES / DATA_SIZE_READ);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WORD_W = DATA_SIZE_READ * 8;
  localparam int LINE_W = CACHELINE_BYTES * 8;

  logic              cmd_issue;
  logic              rd_data_valid;
  logic [7:0]        rd_data_cu_id;
  logic [7:0]        rd_data_struct;
  logic [OFF_W-1:0]  rd_data_offset;
  logic [LINE_W-1:0] rd_data_line;
  logic              rsp_valid;
  logic [7:0]        rsp_cu_id;
  logic [7:0]        rsp_struct;
  logic [7:0]        rsp_code;
  logic              edge_data_pop;
  logic              edge_data_valid;
  logic [WORD_W-1:0] edge_data;
  logic              issue_credit;
  logic [CNT_W-1:0]  outstanding;
  logic [31:0]       done_count;
  logic [2:0]        err_sticky;
  logic [7:0]        err_code;

  modport master (
    output cmd_issue, rd_data_valid, rd_data_cu_id, rd_data_struct, rd_data_offset,
           rd_data_line, rsp_valid, rsp_cu_id, rsp_struct, rsp_code, edge_data_pop,
    input  edge_data_valid, edge_data, issue_credit, outstanding, done_count,
           err_sticky, err_code
  );

  modport slave (
    input  cmd_issue, rd_data_valid, rd_data_cu_id, rd_data_struct, rd_data_offset,
           rd_data_line, rsp_valid, rsp_cu_id, rsp_struct, rsp_code, edge_data_pop,
    output edge_data_valid, edge_data, issue_credit, outstanding, done_count,
           err_sticky, err_code
  );
endinterface

// File: rtl/cu_edge_data_read_extract.sv
// Extracts one element per returned cacheline into a show-ahead FIFO (2-cycle latency),
// and turns outstanding reads + buffered entries into an issue credit so the FIFO never overflows.
module cu_edge_data_read_extract #(
  parameter int         CU_ID           = 1,
  parameter int         DATA_SIZE_READ  = 4,
  parameter int         CACHELINE_BYTES = 128,
  parameter int         DEPTH           = 16,
  parameter logic [7:0] STRUCT_ID       = 8'h02   // READ_GRAPH_DATA
) (
  input  logic                          clock,
  input  logic                          rstn,
  input  logic                          enabled_in,
  cu_edge_data_read_extract_if.slave    io
);
  localparam int OFF_W  = $clog2(CACHELINE_BYTES / DATA_SIZE_READ);
  localparam int WORD_W = DATA_SIZE_READ * 8;
  localparam int LINE_W = CACHELINE_BYTES * 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OCC_W  = CNT_W + 2;
  localparam logic [7:0] CU_ID_B = 8'(CU_ID);

  logic              en_q, en_d;
  logic              s1_dvld_q, s1_dvld_d;
  logic [OFF_W-1:0]  s1_off_q, s1_off_d;
  logic [LINE_W-1:0] s1_line_q, s1_line_d;
  logic              s1_rvld_q, s1_rvld_d;
  logic [7:0]        s1_code_q, s1_code_d;
  logic              s2_vld_q, s2_vld_d;
  logic [WORD_W-1:0] s2_word_q, s2_word_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic              credit_q, credit_d;
  logic [31:0]       done_q, done_d;
  logic [2:0]        err_q, err_d;
  logic [7:0]        err_code_q, err_code_d;

  logic              push, pop, full, push_ok, inc, dec;
  logic [OCC_W-1:0]  occupancy;

  // Stage 1 keeps only matched beats; stage 2 selects the addressed element.
  always_comb begin
    en_d      = enabled_in;
    s1_dvld_d = s1_dvld_q;
    s1_off_d  = s1_off_q;
    s1_line_d = s1_line_q;
    s1_rvld_d = s1_rvld_q;
    s1_code_d = s1_code_q;
    s2_vld_d  = s2_vld_q;
    s2_word_d = s2_word_q;
    if (en_q) begin
      s1_dvld_d = io.rd_data_valid && (io.rd_data_cu_id == CU_ID_B) &&
                  (io.rd_data_struct == STRUCT_ID);
      if (s1_dvld_d) begin
        s1_off_d  = io.rd_data_offset;
        s1_line_d = io.rd_data_line;
      end
      s1_rvld_d = io.rsp_valid && (io.rsp_cu_id == CU_ID_B) && (io.rsp_struct == STRUCT_ID);
      if (s1_rvld_d) s1_code_d = io.rsp_code;
      s2_vld_d = s1_dvld_q;
      if (s1_dvld_q) s2_word_d = s1_line_q[int'(s1_off_q) * WORD_W +: WORD_W];
    end
  end

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    push     = en_q && s2_vld_q;
    pop      = en_q && io.edge_data_pop && (count_q != '0);
    push_ok  = push && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = s2_word_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    inc           = en_q && io.cmd_issue;
    dec           = en_q && s1_dvld_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    done_d        = done_q;
    err_code_d    = err_code_q;
    credit_d      = credit_q;
    if (inc && !dec) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (outstanding_q == '0) err_d[2] = 1'b1;
      else                     outstanding_d = outstanding_q - CNT_W'(1);
    end
    if (push && full && !pop) err_d[1] = 1'b1;
    if (en_q && s1_rvld_q) begin
      if (s1_code_q == 8'h00) begin
        done_d = done_q + 32'd1;
      end else begin
        err_d[0] = 1'b1;
        if (!err_q[0]) err_code_d = s1_code_q;
      end
    end
    // Every slot that could still land in the FIFO counts against the credit.
    occupancy = OCC_W'(outstanding_q) + OCC_W'(s2_vld_q) + OCC_W'(count_q);
    if (en_q) credit_d = (occupancy < OCC_W'(DEPTH));
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      en_q          <= 1'b0;
      s1_dvld_q     <= 1'b0;
      s1_off_q      <= '0;
      s1_line_q     <= '0;
      s1_rvld_q     <= 1'b0;
      s1_code_q     <= '0;
      s2_vld_q      <= 1'b0;
      s2_word_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      credit_q      <= 1'b0;
      done_q        <= '0;
      err_q         <= '0;
      err_code_q    <= '0;
    end else begin
      en_q          <= en_d;
      s1_dvld_q     <= s1_dvld_d;
      s1_off_q      <= s1_off_d;
      s1_line_q     <= s1_line_d;
      s1_rvld_q     <= s1_rvld_d;
      s1_code_q     <= s1_code_d;
      s2_vld_q      <= s2_vld_d;
      s2_word_q     <= s2_word_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      credit_q      <= credit_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign io.edge_data_valid = (count_q != '0);
  assign io.edge_data       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign io.issue_credit    = credit_q;
  assign io.outstanding     = outstanding_q;
  assign io.done_count      = done_q;
  assign io.err_sticky      = err_q;
  assign io.err_code        = err_code_q;
endmodule

// File: tb/tb_cu_edge_data_read_extract.sv
// Directed bench: stimulus pushes expected FIFO words into a queue, a monitor pops
// and compares whenever the DUT presents data and popping is allowed.
module tb_cu_edge_data_read_extract;
  localparam logic [7:0] CUID = 8'h01;
  localparam logic [7:0] SID  = 8'h02;

  logic clock = 1'b0;
  logic rstn = 1'b0;
  logic enabled_in = 1'b0;
  always #5 clock = ~clock;

  cu_edge_data_read_extract_if #(.DATA_SIZE_READ(4), .CACHELINE_BYTES(128), .DEPTH(16)) io();

  cu_edge_data_read_extract #(
    .CU_ID(1), .DATA_SIZE_READ(4), .CACHELINE_BYTES(128), .DEPTH(16), .STRUCT_ID(SID)
  ) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .io(io)
  );

  int          total = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];
  bit          pop_all = 1'b0;
  int          pop_budget = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [1023:0] make_line(input logic [7:0] seed);
    logic [1023:0] l;
    for (int i = 0; i < 128; i++) l[i*8 +: 8] = seed + 8'(i);
    return l;
  endfunction

  function automatic logic [31:0] word0(input logic [7:0] s);
    return {s + 8'd3, s + 8'd2, s + 8'd1, s};
  endfunction

  task automatic send_line(input logic [7:0] cu, input logic [7:0] st,
                           input logic [4:0] off, input logic [1023:0] line);
    io.rd_data_valid  = 1'b1;
    io.rd_data_cu_id  = cu;
    io.rd_data_struct = st;
    io.rd_data_offset = off;
    io.rd_data_line   = line;
    @(negedge clock);
    io.rd_data_valid  = 1'b0;
  endtask

  task automatic send_rsp(input logic [7:0] cu, input logic [7:0] code);
    io.rsp_valid  = 1'b1;
    io.rsp_cu_id  = cu;
    io.rsp_struct = SID;
    io.rsp_code   = code;
    @(negedge clock);
    io.rsp_valid  = 1'b0;
  endtask

  task automatic issue(input int n);
    io.cmd_issue = 1'b1;
    repeat (n) @(negedge clock);
    io.cmd_issue = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},       64'(io.edge_data_valid), 64'd0);
    check({tag, "_edge_data"},   64'(io.edge_data),       64'd0);
    check({tag, "_credit"},      64'(io.issue_credit),    64'd0);
    check({tag, "_outstanding"}, 64'(io.outstanding),     64'd0);
    check({tag, "_done_count"},  64'(io.done_count),      64'd0);
    check({tag, "_err_sticky"},  64'(io.err_sticky),      64'd0);
    check({tag, "_err_code"},    64'(io.err_code),        64'd0);
  endtask

  // Monitor: compare the FIFO head against the scoreboard and pop it.
  initial begin
    io.edge_data_pop = 1'b0;
    forever begin
      @(negedge clock);
      io.edge_data_pop = 1'b0;
      if (rstn && io.edge_data_valid && (pop_all || pop_budget > 0)) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_data: got 0x%0h required no entry", io.edge_data);
        end else begin
          check("edge_data", 64'(io.edge_data), 64'(exp_q.pop_front()));
        end
        io.edge_data_pop = 1'b1;
        if (!pop_all) pop_budget--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  offs [3];
    logic [31:0] exps [3];
    offs = '{5'd0, 5'd1, 5'd31};
    exps = '{32'h03020100, 32'h07060504, 32'h7F7E7D7C};
    io.cmd_issue = 1'b0; io.rd_data_valid = 1'b0; io.rd_data_cu_id = '0;
    io.rd_data_struct = '0; io.rd_data_offset = '0; io.rd_data_line = '0;
    io.rsp_valid = 1'b0; io.rsp_cu_id = '0; io.rsp_struct = '0; io.rsp_code = '0;

    tick(2);
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick(1);
    enabled_in = 1'b1;
    tick(1);
    check("credit_enable_plus1", 64'(io.issue_credit), 64'd0);
    tick(1);
    check("credit_enable_plus2", 64'(io.issue_credit), 64'd1);

    // Element extraction at offsets 0, 1, 31 with two-cycle latency.
    pop_all = 1'b1;
    issue(3);
    tick(2);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exps[i]);
      send_line(CUID, SID, offs[i], make_line(8'h00));
      tick(1);
      check("latency_k1_not_valid", 64'(io.edge_data_valid), 64'd0);
      tick(1);
      check("latency_k2_valid", 64'(io.edge_data_valid), 64'd1);
      tick(2);
    end
    check("offsets_outstanding", 64'(io.outstanding), 64'd0);

    // Non-matching cu_id and struct are ignored.
    send_line(CUID + 8'd1, SID, 5'd0, make_line(8'h40));
    send_line(CUID, SID + 8'd1, 5'd0, make_line(8'h50));
    tick(4);
    check("filter_outstanding", 64'(io.outstanding), 64'd0);
    check("filter_err", 64'(io.err_sticky), 64'd0);
    check("filter_no_push", 64'(io.edge_data_valid), 64'd0);

    // Credit exhaustion and recovery after a single pop.
    issue(16);
    tick(2);
    check("credit_outstanding16", 64'(io.outstanding), 64'd16);
    check("credit_zero_at16", 64'(io.issue_credit), 64'd0);
    pop_all = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(word0(8'(8'h10 + i)));
      send_line(CUID, SID, 5'd0, make_line(8'(8'h10 + i)));
    end
    tick(4);
    check("credit_returned_outstanding", 64'(io.outstanding), 64'd0);
    check("credit_zero_fifo_full", 64'(io.issue_credit), 64'd0);
    pop_budget = 1;
    tick(3);
    check("credit_after_pop", 64'(io.issue_credit), 64'd1);
    pop_all = 1'b1;
    drain();

    // Overflow: 17 returns into a 16-entry FIFO with nothing popping.
    pop_all = 1'b0;
    issue(17);
    tick(2);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(word0(8'(8'h80 + i)));
      send_line(CUID, SID, 5'd0, make_line(8'(8'h80 + i)));
    end
    tick(4);
    check("overflow_err", 64'(io.err_sticky), 64'd2);
    check("overflow_head", 64'(io.edge_data), 64'(word0(8'h80)));
    check("overflow_outstanding", 64'(io.outstanding), 64'd0);
    pop_all = 1'b1;
    drain();
    tick(2);
    check("overflow_drained", 64'(io.edge_data_valid), 64'd0);

    // Responses: foreign response ignored, first matched error code captured.
    send_rsp(CUID + 8'd1, 8'h07);
    send_rsp(CUID, 8'h00);
    send_rsp(CUID, 8'h00);
    send_rsp(CUID, 8'h05);
    send_rsp(CUID, 8'h0A);
    tick(3);
    check("rsp_done_count", 64'(io.done_count), 64'd2);
    check("rsp_err_sticky", 64'(io.err_sticky), 64'd3);
    check("rsp_err_code", 64'(io.err_code), 64'h05);

    // Reset with 5 entries queued and 3 commands outstanding.
    pop_all = 1'b0;
    issue(8);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(word0(8'(8'hC0 + i)));
      send_line(CUID, SID, 5'd0, make_line(8'(8'hC0 + i)));
    end
    tick(4);
    check("prereset_outstanding", 64'(io.outstanding), 64'd3);
    check("prereset_head", 64'(io.edge_data), 64'(word0(8'hC0)));
    exp_q.delete();
    #2 rstn = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clock);
    rstn = 1'b1;
    pop_all = 1'b1;
    tick(10);
    check("postreset_no_data", 64'(io.edge_data_valid), 64'd0);
    check("postreset_outstanding", 64'(io.outstanding), 64'd0);
    check("postreset_credit", 64'(io.issue_credit), 64'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/cu_edge_data_read_extract.md
# cu_edge_data_read_extract

Receive-side companion to the compute unit's edge-data read issuer. It takes CAPI read-data cachelines and read responses tagged for this CU with vertex struct READ_GRAPH_DATA. From each cacheline it extracts the single DATA_SIZE_READ-byte element named by the command's cacheline offset and buffers it in a show-ahead FIFO for the edge-data consumer. It also tracks outstanding read commands and produces an issue credit so the issuer can never overflow the FIFO.

## Interface
Parameters:
- CU_ID, 1, compute-unit id to match on returned data and responses.
- DATA_SIZE_READ, 4, element size in bytes (power of two).
- CACHELINE_BYTES, 128, returned line size in bytes.
- DEPTH, 16, output FIFO entries (power of two).
- STRUCT_ID, READ_GRAPH_DATA, vertex_struct value to accept.
- OFF_W = log2(CACHELINE_BYTES/DATA_SIZE_READ), derived (5 at defaults).

Ports:
- clock  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- enabled_in  in  1  block enable; registered once internally.
- cmd_issue  in  1  one pulse per read command accepted downstream of the issuer.
- rd_data_valid  in  1  cacheline beat valid.
- rd_data_cu_id  in  8  CU id carried with the line.
- rd_data_struct  in  8  vertex_struct carried with the line.
- rd_data_offset  in  OFF_W  element index in the line.
- rd_data_line  in  CACHELINE_BYTES*8  line data, byte 0 at bits [7:0].
- rsp_valid  in  1  response valid.
- rsp_cu_id  in  8  response CU id.
- rsp_struct  in  8  response vertex_struct.
- rsp_code  in  8  response code; 0x00 = DONE.
- edge_data_pop  in  1  consumer pop.
- edge_data_valid  out  1  FIFO not empty.
- edge_data  out  DATA_SIZE_READ*8  FIFO head.
- issue_credit  out  1  one more command may be issued.
- outstanding  out  log2(DEPTH)+1  commands issued and not yet returned.
- done_count  out  32  DONE responses accepted.
- err_sticky  out  3  bit0 bad response, bit1 FIFO overflow, bit2 outstanding underflow.
- err_code  out  8  first non-DONE rsp_code captured.

## Operation
- Stage 1 register: captures rd_data_* and rsp_* each cycle while enabled.
- Match rule: cu_id == CU_ID and struct == STRUCT_ID. Non-matching inputs are ignored entirely: no push, no count change.
- Stage 2 register: word = line[offset*DATA_SIZE_READ*8 +: DATA_SIZE_READ*8]; valid = matched stage-1 data valid.
- Stage 2 valid pushes into the FIFO. Push while full: the entry is dropped and err_sticky[1] is set.
- Pop is honoured only when edge_data_valid is high; pop on empty is ignored.
- outstanding update:
  - +1 on cmd_issue.
  - −1 on a matched stage-1 data valid.
  - Both in the same cycle: unchanged.
  - Decrement at 0: stays 0 and sets err_sticky[2].
- occupancy = outstanding + stage-2 valid + FIFO count.
- issue_credit = occupancy < DEPTH, registered.
- Matched response with code 0x00: done_count +1, wrapping at 2^32.
- Matched response with any other code: sets err_sticky[0]; err_code is loaded only on the first such event.
- enabled low: stages, counters and FIFO hold. Pops are ignored. cmd_issue is ignored.
- Reset mid-operation: all state and FIFO contents are cleared immediately. In-flight data is discarded.

## Timing
- Reset values:
  - edge_data_valid 0, edge_data 0.
  - issue_credit 0; it becomes 1 on the second cycle after enable rises.
  - outstanding 0, done_count 0, err_sticky 0, err_code 0.
- Latency: matched data sampled at edge k gives edge_data_valid high after edge k+2 if the FIFO was empty.
- FIFO: show-ahead; edge_data is valid in the same cycle as edge_data_valid. Pop at edge j exposes the next entry after edge j.
- Simultaneous push and pop when full: the pop frees a slot and the push is accepted; no overflow error.
- outstanding updates the edge after stage-1 capture, and the edge after cmd_issue.
- issue_credit lags occupancy by one cycle. The issuer must not assert cmd_issue more than once per credit-high cycle.

## Test plan
- Offsets: push lines with bytes = index and offsets 0, 1, 31 → edge_data = 0x03020100, 0x07060504, 0x7F7E7D7C, in order, each 2 cycles after input.
- Filtering: data with cu_id = CU_ID+1, then struct ≠ STRUCT_ID → no push; outstanding unchanged.
- Credit: 16 cmd_issue pulses with no returns → outstanding = 16, issue_credit = 0. Return 16 lines, pop 1 → issue_credit = 1.
- Overflow: fill the FIFO with credit ignored, then one more push → entry dropped, err_sticky = 3'b010, FIFO head unchanged.
- Responses: codes 0x00, 0x00, 0x05, 0x0A → done_count = 2, err_sticky[0] = 1, err_code = 0x05.
- Reset: assert rstn low with 5 entries queued and outstanding = 3 → all outputs return to reset values; post-reset pop yields nothing.
